// File: rtl/spi_stream_tx_if.sv
`timescale 1ns/1ps
// Byte-stream valid/ready link feeding the SPI transmitter.
interface spi_stream_tx_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    // Word source: offers data, sees the accept.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // Transmitter side: consumes words.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/spi_stream_tx.sv
`timescale 1ns/1ps
// SPI mode-0 transmitter: shifts stream words out MSB-first on MISO with a generated SPI_clk
// while the receiver holds chip_select high. Back-to-back words run with no clock gap.
module spi_stream_tx #(
    parameter int unsigned SCLK_HALF = 20,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             CLK_40,
    input  logic             reset_n,
    input  logic             chip_select,
    spi_stream_tx_if.slave   tx,
    output logic             SPI_clk,
    output logic             MISO,
    output logic             busy,
    output logic             aborted,
    output logic             underrun,
    output logic [CNT_W-1:0] byte_count
);
    localparam int unsigned HalfW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int unsigned BitW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [HalfW-1:0] HalfLast = HalfW'(SCLK_HALF - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

    state_e              state_q, state_d;
    logic                cs_meta_q, cs_s_q;
    logic [HalfW-1:0]    half_cnt_q, half_cnt_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    byte_count_q, byte_count_d;
    logic                aborted_q, aborted_d;
    logic                underrun_q, underrun_d;

    logic cs_rise;
    logic half_term;
    logic last_edge;
    logic accept;
    logic tx_ready;

    // Two-flop synchronizer for the asynchronous chip_select request.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta_q <= 1'b0;
            cs_s_q    <= 1'b0;
        end else begin
            cs_meta_q <= chip_select;
            cs_s_q    <= cs_meta_q;
        end
    end

    // Rising edge flagged on the same clock that cs_s goes high, so the count clears with it.
    assign cs_rise   = cs_meta_q & ~cs_s_q;
    assign half_term = (half_cnt_q == HalfLast);
    assign last_edge = half_term && (bit_cnt_q == '0);
    assign accept    = tx.tx_valid && tx_ready;

    // State register and shift/counter datapath.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            half_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_count_q <= '0;
            aborted_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_count_q <= byte_count_d;
            aborted_q    <= aborted_d;
            underrun_q   <= underrun_d;
        end
    end

    // Next-state: half-period timing, bit sequencing, word completion and abort handling.
    always_comb begin
        state_d      = state_q;
        half_cnt_d   = half_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_count_d = byte_count_q;
        aborted_d    = 1'b0;
        underrun_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d    = tx.tx_data;
                    bit_cnt_d  = BitLast;
                    half_cnt_d = '0;
                    state_d    = StLow;
                end
            end
            StLow: begin
                if (!cs_s_q) begin
                    state_d    = StIdle;
                    aborted_d  = 1'b1;
                    shift_d    = '0;
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else if (half_term) begin
                    half_cnt_d = '0;
                    state_d    = StHigh;
                end else begin
                    half_cnt_d = half_cnt_q + HalfW'(1);
                end
            end
            StHigh: begin
                if (last_edge) begin
                    // Word complete even if cs_s fell on this very cycle.
                    byte_count_d = byte_count_q + CNT_W'(1);
                    half_cnt_d   = '0;
                    if (accept) begin
                        shift_d   = tx.tx_data;
                        bit_cnt_d = BitLast;
                        state_d   = StLow;
                    end else begin
                        underrun_d = cs_s_q;
                        shift_d    = '0;
                        bit_cnt_d  = '0;
                        state_d    = StIdle;
                    end
                end else if (!cs_s_q) begin
                    state_d    = StIdle;
                    aborted_d  = 1'b1;
                    shift_d    = '0;
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else if (half_term) begin
                    shift_d    = {shift_q[DATA_W-2:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q - BitW'(1);
                    half_cnt_d = '0;
                    state_d    = StLow;
                end else begin
                    half_cnt_d = half_cnt_q + HalfW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (cs_rise) begin
            byte_count_d = '0;
        end
    end

    // Outputs decoded from the registered state; MISO is forced low whenever idle.
    always_comb begin
        SPI_clk  = 1'b0;
        MISO     = 1'b0;
        busy     = 1'b0;
        tx_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_ready = cs_s_q;
            end
            StLow: begin
                MISO = shift_q[DATA_W-1];
                busy = 1'b1;
            end
            StHigh: begin
                SPI_clk  = 1'b1;
                MISO     = shift_q[DATA_W-1];
                busy     = 1'b1;
                tx_ready = cs_s_q & last_edge;
            end
            default: begin
                tx_ready = 1'b0;
            end
        endcase
    end

    assign tx.tx_ready = tx_ready;
    assign aborted     = aborted_q;
    assign underrun    = underrun_q;
    assign byte_count  = byte_count_q;
endmodule

// File: doc/spi_stream_tx.md
Name: spi_stream_tx

Overview:
- SPI-style serial transmitter: the sending end of the MISO/SPI_clk/chip_select link that the data-acquisition path receives.
- Generates SPI_clk and drives MISO MSB-first from a byte-stream valid/ready source, while the receiver's chip_select request is asserted.
- Used as an on-FPGA loopback/stimulus source (second board or GPIO loop) to exercise the receive path without the external microcontroller.

Parameters:
- SCLK_HALF, 20, CLK_40 cycles per SPI_clk half-period (default gives 1 MHz); legal range ≥4, so the receiver's 2-FF sync plus edge detect resolves every edge.
- DATA_W, 8, bits per transfer word.
- CNT_W, 16, width of byte_count.

Ports:
- CLK_40  input  1  40 MHz system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- chip_select  input  1  receiver's request; active-high; asynchronous to CLK_40, synchronized internally.
- tx_data  input  DATA_W  word to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  word accepted this cycle when tx_valid&&tx_ready.
- SPI_clk  output  1  serial clock; idle low (mode 0).
- MISO  output  1  serial data; changes only while SPI_clk low.
- busy  output  1  high while a word is being shifted.
- aborted  output  1  one-cycle pulse: chip_select dropped mid-word.
- underrun  output  1  one-cycle pulse: word finished, chip_select still high, no tx_valid.
- byte_count  output  CNT_W  words fully sent since the last chip_select rising edge.

Behaviour:
- Reset (async assert, sync release): state IDLE; SPI_clk=0, MISO=0, tx_ready=0, busy=0, aborted=0, underrun=0, byte_count=0, shift reg=0, counters=0.
- chip_select passes a 2-FF synchronizer to give cs_s (2-cycle latency). A cs_s rising edge clears byte_count.
- States: IDLE, LOW, HIGH.
- IDLE:
  - SPI_clk=0, MISO=0, busy=0.
  - tx_ready = cs_s.
  - On accept at cycle t: load shift reg, bit_cnt=DATA_W-1, half_cnt=0, go LOW.
  - At t+1: MISO=tx_data[DATA_W-1], busy=1.
- LOW:
  - SPI_clk=0; half_cnt counts 0..SCLK_HALF-1.
  - On the terminal count, go HIGH (SPI_clk=1 on the next cycle).
- HIGH:
  - SPI_clk=1; half_cnt counts 0..SCLK_HALF-1. On the terminal count:
  - If bit_cnt>0: shift left, decrement bit_cnt, go LOW. MISO shows the next bit in the same cycle SPI_clk falls.
  - If bit_cnt==0: byte_count++ (wraps at 2^CNT_W), and tx_ready = cs_s in this cycle.
    - Accept: reload and go LOW. new[MSB] and the SPI_clk falling edge appear together; the bit stream is continuous, no gap.
    - No accept and cs_s=1: pulse underrun, go IDLE.
    - cs_s=0: go IDLE, no pulse.
- Timing:
  - Rising edges at t+1+SCLK_HALF+2k·SCLK_HALF; MISO stable for SCLK_HALF cycles before and after each rising edge.
  - One word = 2·DATA_W·SCLK_HALF cycles.
- tx_ready is 0 in LOW, and 0 in HIGH except the terminal cycle of the last bit.
- cs_s falls while in LOW/HIGH:
  - Next cycle: go IDLE, SPI_clk=0, MISO=0, pulse aborted.
  - The partial word is discarded and byte_count is not incremented.
  - Exception: a fall coincident with the bit-0 terminal cycle counts as word complete, with no aborted pulse.
- tx_valid dropping while busy has no effect; the word is already latched.
- cs_s rising edge in the same cycle as an accept: byte_count clears, and the word will be counted when it completes.

Test Plan:
- Reset mid-word (reset_n low during HIGH of bit 3) -> all outputs 0 immediately (asynchronous); after release, IDLE with tx_ready=0 until cs_s=1.
- chip_select=1, single word 0xA5, SCLK_HALF=20 -> tx_ready pulse at t; MISO pattern 1,0,1,0,0,1,0,1 sampled at rising edges t+21, t+61, …, t+301; then underrun pulse and byte_count=1.
- Back-to-back 0x3C,0xFF,0x00 with tx_valid held -> continuous 24 SPI_clk periods with no idle gap; tx_ready pulses exactly 3 times, 320 cycles apart; byte_count=3.
- chip_select dropped after the 4th rising edge of 0x81 -> within 3 cycles (2 sync + 1) SPI_clk=0, MISO=0, one aborted pulse; byte_count unchanged; next word starts at MSB.
- Loopback into the existing receive path (GPIO_0[0]/[1]) with 24 words 0x00..0x17 -> received bitstream equals the sent words MSB-first; HEX shows 0x151617.
- chip_select reasserted after a transfer -> byte_count clears to 0 two cycles after the raw rising edge; SCLK_HALF=4 run -> every bit still received correctly.
